// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the IF-stage sequencing controller:
//   - fetch_state_e : one-hot state encoding (HOLD / RUN / REDIRECT)
//   - XLEN_DEFAULT  : default PC / branch-target width
//   - NOP_FLUSH     : instruction word the IF/ID register loads on if_flush
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;

    // addi x0, x0, 0 -- the IF/ID register substitutes this word when flushed
    localparam logic [31:0] NOP_FLUSH = 32'h0000_0013;

    // One-hot so that any corrupted encoding is detectable and falls to HOLD
    typedef enum logic [2:0] {
        HOLD     = 3'b001,
        RUN      = 3'b010,
        REDIRECT = 3'b100
    } fetch_state_e;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Bundles the controller's hazard/branch/memory inputs and fetch-stage outputs.
//   master : the fetch controller (drives control outputs, reads requests)
//   slave  : the surrounding pipeline (drives requests, reads control outputs)
// Parameters: XLEN (PC width), CNT_W (performance counter width).
// -----------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) ();

    logic             branch_taken;
    logic [XLEN-1:0]  branch_target;
    logic             load_use_hazard;
    logic             imem_ready;
    logic             imem_req;
    logic             mux_sel;
    logic [XLEN-1:0]  pc_branch_value;
    logic             load_pc;
    logic             load_if_id_register;
    logic             if_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        input  branch_taken, branch_target, load_use_hazard, imem_ready,
        output imem_req, mux_sel, pc_branch_value, load_pc,
               load_if_id_register, if_flush, stall_cycles, flush_events
    );

    modport slave (
        output branch_taken, branch_target, load_use_hazard, imem_ready,
        input  imem_req, mux_sel, pc_branch_value, load_pc,
               load_if_id_register, if_flush, stall_cycles, flush_events
    );

endinterface : fetch_ctrl_if

// File: rtl/fetch_ctrl_perf.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_perf
// Two saturating performance counters for the fetch controller.
// Ports:
//   clock        : system clock
//   reset        : synchronous active-low reset, clears both counters
//   stall_inc    : count one stalled RUN cycle
//   flush_inc    : count one accepted branch
//   stall_cycles : stalled-cycle count (saturates at all-ones)
//   flush_events : branch-flush count (saturates at all-ones)
// -----------------------------------------------------------------------------
module fetch_ctrl_perf #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Add one unless already pinned at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_W'(1);
        end
    endfunction

    // Counter registers with synchronous clear
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (flush_inc) begin
                flush_events <= sat_inc(flush_events);
            end
        end
    end

endmodule : fetch_ctrl_perf

// File: rtl/fetch_control.sv
// -----------------------------------------------------------------------------
// fetch_control
// Sequencing controller for the IF stage: each cycle decides whether the fetch
// advances, freezes, redirects to a branch target or flushes IF/ID.
// Ports:
//   clock : system clock, all state updates on its rising edge
//   reset : synchronous active-low reset
//   bus   : fetch_ctrl_if.master -- branch_taken/branch_target, load_use_hazard,
//           imem_ready in; imem_req, mux_sel, pc_branch_value, load_pc,
//           load_if_id_register, if_flush, stall_cycles, flush_events out
// Configuration: define FETCH_CTRL_PERF_EN to build the performance counters;
// otherwise stall_cycles/flush_events are tied to zero.
// Control outputs are a combinational decode of state and inputs; the state,
// the post-reset hold counter and pc_branch_value are registered.
// -----------------------------------------------------------------------------
module fetch_control
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN              = XLEN_DEFAULT,
    parameter int RESET_HOLD_CYCLES = 2,
    parameter int CNT_W             = 16
) (
    input  logic         clock,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    fetch_state_e      state_r;
    fetch_state_e      state_s;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_s;
    logic [XLEN-1:0]   pc_branch_r;
    logic [XLEN-1:0]   pc_branch_s;

    logic imem_req_s;
    logic mux_sel_s;
    logic load_pc_s;
    logic load_if_id_s;
    logic if_flush_s;

    // State, hold counter and redirect target registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= HOLD;
            hold_cnt_r  <= '0;
            pc_branch_r <= '0;
        end else begin
            state_r     <= state_s;
            hold_cnt_r  <= hold_cnt_s;
            pc_branch_r <= pc_branch_s;
        end
    end

    // Next-state and control-output decode
    always_comb begin
        state_s      = state_r;
        hold_cnt_s   = '0;
        pc_branch_s  = pc_branch_r;
        imem_req_s   = 1'b0;
        mux_sel_s    = 1'b0;
        load_pc_s    = 1'b0;
        load_if_id_s = 1'b0;
        if_flush_s   = 1'b0;
        case (state_r)
            HOLD: begin
                // Inputs ignored; leave once the hold counter has run out
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s = RUN;
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                end
            end
            RUN: begin
                imem_req_s = 1'b1;
                if (bus.branch_taken) begin
                    // Squash the wrong-path fetch now, redirect next cycle
                    if_flush_s  = 1'b1;
                    pc_branch_s = bus.branch_target;
                    state_s     = REDIRECT;
                end else if (bus.load_use_hazard) begin
                    state_s = RUN;
                end else if (!bus.imem_ready) begin
                    state_s = RUN;
                end else begin
                    load_pc_s    = 1'b1;
                    load_if_id_s = 1'b1;
                end
            end
            REDIRECT: begin
                // Load the captured target; the fetched word is wrong-path
                mux_sel_s  = 1'b1;
                load_pc_s  = 1'b1;
                if_flush_s = 1'b1;
                state_s    = RUN;
            end
            default: begin
                state_s = HOLD;
            end
        endcase
    end

    assign bus.imem_req            = imem_req_s;
    assign bus.mux_sel             = mux_sel_s;
    assign bus.load_pc             = load_pc_s;
    assign bus.load_if_id_register = load_if_id_s;
    assign bus.if_flush            = if_flush_s;
    assign bus.pc_branch_value     = pc_branch_r;

`ifdef FETCH_CTRL_PERF_EN
    logic stall_inc_s;
    logic flush_inc_s;

    // Stall: RUN cycle without a PC load and without a branch
    assign stall_inc_s = (state_r == RUN) && !load_pc_s && !bus.branch_taken;
    assign flush_inc_s = (state_r == RUN) && bus.branch_taken;

    fetch_ctrl_perf #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clock        (clock),
        .reset        (reset),
        .stall_inc    (stall_inc_s),
        .flush_inc    (flush_inc_s),
        .stall_cycles (bus.stall_cycles),
        .flush_events (bus.flush_events)
    );
`else
    assign bus.stall_cycles = CNT_W'(0);
    assign bus.flush_events = CNT_W'(0);
`endif

endmodule : fetch_control

// File: tb/tb_fetch_control.sv
// -----------------------------------------------------------------------------
// tb_fetch_control
// Directed bench for fetch_control: each step drives one cycle of inputs and
// pushes the expected outputs for that cycle; the outputs are popped and
// compared half a cycle later.
// -----------------------------------------------------------------------------
module tb_fetch_control;

`ifdef FETCH_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic        imem_req;
        logic        mux_sel;
        logic        load_pc;
        logic        load_if_id;
        logic        if_flush;
        logic [31:0] pc_val;
        logic [15:0] stalls;
        logic [15:0] flushes;
    } exp_t;

    logic clock;
    logic reset;
    int   errors;
    int   checks;
    exp_t sb_q[$];

    fetch_ctrl_if #(.XLEN(32), .CNT_W(16)) bus ();

    fetch_control #(
        .XLEN              (32),
        .RESET_HOLD_CYCLES (2),
        .CNT_W             (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_field(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, check at the negedge
    task automatic step(input logic rst, input logic bt, input logic [31:0] tgt,
                        input logic luh, input logic rdy,
                        input logic req, input logic mux, input logic lpc,
                        input logic lid, input logic flush, input logic [31:0] pcv,
                        input logic [15:0] stl, input logic [15:0] fls);
        exp_t e;
        exp_t got;
        reset               = rst;
        bus.branch_taken    = bt;
        bus.branch_target   = tgt;
        bus.load_use_hazard = luh;
        bus.imem_ready      = rdy;
        e.imem_req   = req;
        e.mux_sel    = mux;
        e.load_pc    = lpc;
        e.load_if_id = lid;
        e.if_flush   = flush;
        e.pc_val     = pcv;
        e.stalls     = PERF ? stl : 16'd0;
        e.flushes    = PERF ? fls : 16'd0;
        sb_q.push_back(e);
        @(negedge clock);
        got = sb_q.pop_front();
        check_field("imem_req",        32'(bus.imem_req),            32'(got.imem_req));
        check_field("mux_sel",         32'(bus.mux_sel),             32'(got.mux_sel));
        check_field("load_pc",         32'(bus.load_pc),             32'(got.load_pc));
        check_field("load_if_id",      32'(bus.load_if_id_register), 32'(got.load_if_id));
        check_field("if_flush",        32'(bus.if_flush),            32'(got.if_flush));
        check_field("pc_branch_value", bus.pc_branch_value,          got.pc_val);
        check_field("stall_cycles",    32'(bus.stall_cycles),        32'(got.stalls));
        check_field("flush_events",    32'(bus.flush_events),        32'(got.flushes));
        @(posedge clock);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset               = 1'b0;
        bus.branch_taken    = 1'b0;
        bus.branch_target   = 32'h0;
        bus.load_use_hazard = 1'b0;
        bus.imem_ready      = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        //    rst   bt    tgt           luh   rdy   req   mux   lpc   lid   fl    pc            stl    fls
        // Reset release: two frozen cycles, then fetch starts
        step(1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        16'd0, 16'd0);
        step(1'b1, 1'b1, 32'h99,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        16'd0, 16'd0);
        // Normal run
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        16'd0, 16'd0);
        end
        // Taken branch to 0x10
        step(1'b1, 1'b1, 32'h10,      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        16'd0, 16'd0);
        step(1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10,       16'd0, 16'd1);
        step(1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10,       16'd0, 16'd1);
        // Branch + hazard + wait together; branch held through REDIRECT is ignored
        step(1'b1, 1'b1, 32'h20,      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10,       16'd0, 16'd1);
        step(1'b1, 1'b1, 32'h30,      1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20,       16'd0, 16'd2);
        step(1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20,       16'd0, 16'd2);
        // Load-use hazard for 2 cycles, then memory wait for 3
        step(1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,       16'd0, 16'd2);
        step(1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,       16'd1, 16'd2);
        step(1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,       16'd2, 16'd2);
        step(1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,       16'd3, 16'd2);
        step(1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20,       16'd4, 16'd2);
        step(1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20,       16'd5, 16'd2);
        // Reset asserted while in REDIRECT
        step(1'b1, 1'b1, 32'h44,      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h20,       16'd5, 16'd2);
        step(1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h44,       16'd5, 16'd3);
        step(1'b1, 1'b1, 32'h55,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        16'd0, 16'd0);
        step(1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        16'd0, 16'd0);
        step(1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        16'd0, 16'd0);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_control
